// File: rtl/bus_arbiter_pkg.sv
// Shared types and helpers for the N-master bus arbiter: FSM state encoding,
// chipselect decode and burst-counter width derivation.
package bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    BEAT = 2'd2
  } state_t;

  function automatic int bus_clog2(input int value);
    int result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

  function automatic int bcw_of(input int burstMax);
    return bus_clog2(burstMax) + 1;
  endfunction

  // One-hot select from the top address nibble; nibbles at or above the slave count decode to zero.
  function automatic logic [15:0] decode_cs(input logic [3:0] nibble, input int slaves);
    logic [15:0] cs;
    cs = '0;
    if (int'(nibble) < slaves) cs[nibble] = 1'b1;
    return cs;
  endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Bus bundle between requesting masters, the arbiter and the SoC slaves.
// master = the arbiter's own view (it drives the shared bus); slave = requester/slave side.
interface bus_arbiter_if #(
  parameter int MASTERS = 4,
  parameter int SLAVES  = 10,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int BCW     = 3
);
  logic [MASTERS-1:0]        m_read;
  logic [MASTERS-1:0]        m_write;
  logic [MASTERS*AW-1:0]     m_address;
  logic [MASTERS*DW-1:0]     m_writedata;
  logic [MASTERS*DW/8-1:0]   m_be;
  logic [MASTERS*BCW-1:0]    m_burstcount;
  logic [MASTERS-1:0]        m_wait;
  logic [MASTERS-1:0]        grant;
  logic [AW-1:0]             address;
  logic                      read;
  logic                      write;
  logic [DW-1:0]             writedata;
  logic [DW/8-1:0]           be;
  logic [SLAVES-1:0]         chipselect;
  logic                      start;
  logic                      burst;
  logic                      burst_adv;
  logic                      slave_wait;
  logic                      bus_err;

  modport master (
    input  m_read, m_write, m_address, m_writedata, m_be, m_burstcount, slave_wait,
    output m_wait, grant, address, read, write, writedata, be, chipselect,
           start, burst, burst_adv, bus_err
  );

  modport slave (
    output m_read, m_write, m_address, m_writedata, m_be, m_burstcount, slave_wait,
    input  m_wait, grant, address, read, write, writedata, be, chipselect,
           start, burst, burst_adv, bus_err
  );

endinterface

// File: rtl/bus_arbiter_rr.sv
// Request picker: fixed (lowest index wins) or round-robin starting after the last winner.
// The round-robin pointer lives here and only moves when the arbiter accepts a grant.
module bus_rr_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int MASTERS = 4,
  parameter bit RR_MODE = 1'b1,
  localparam int IW = (MASTERS > 1) ? bus_clog2(MASTERS) : 1
) (
  input  logic               i_clock,
  input  logic               i_reset_n,
  input  logic [MASTERS-1:0] i_req,
  input  logic               i_accept,
  output logic [MASTERS-1:0] o_winner,
  output logic [IW-1:0]      o_winnerIdx
);

  logic [IW-1:0] r_ptr;
  logic [IW-1:0] w_idx;
  logic [IW-1:0] w_cand;

  // Scanning from the farthest candidate down lets the closest requester overwrite earlier hits.
  always_comb begin
    w_idx  = '0;
    w_cand = '0;
    if (RR_MODE) begin
      for (int k = MASTERS; k >= 1; k--) begin
        w_cand = IW'((int'(r_ptr) + k) % MASTERS);
        if (i_req[w_cand]) w_idx = w_cand;
      end
    end else begin
      for (int k = MASTERS - 1; k >= 0; k--) begin
        w_cand = IW'(k);
        if (i_req[w_cand]) w_idx = w_cand;
      end
    end
  end

  assign o_winnerIdx = w_idx;
  assign o_winner    = (|i_req) ? (MASTERS'(1) << w_idx) : '0;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_ptr <= IW'(MASTERS - 1);
    end else if (i_accept) begin
      r_ptr <= w_idx;
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// N-master bus arbiter and address decoder with native (SSRAM) or split burst sequencing.
// Drives the shared address/write path, one-hot chipselect and start/burst/burst_adv strobes.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int              MASTERS    = 4,
  parameter int              SLAVES     = 10,
  parameter int              AW         = 32,
  parameter int              DW         = 32,
  parameter int              BURST_MAX  = 4,
  parameter bit              RR_MODE    = 1'b1,
  parameter logic [SLAVES-1:0] BURST_MASK = 'h001
) (
  input  logic            i_clock,
  input  logic            i_reset_n,
  bus_arbiter_if.master   bus
);

  localparam int BCW = bcw_of(BURST_MAX);
  localparam int BEW = DW / 8;
  localparam int IW  = (MASTERS > 1) ? bus_clog2(MASTERS) : 1;
  localparam logic [AW-1:0] STEP   = AW'(DW / 8);
  localparam logic [15:0]   MASK16 = 16'(BURST_MASK);

  state_t             r_state;
  state_t             w_nextState;

  logic [MASTERS-1:0] w_req;
  logic [MASTERS-1:0] w_winner;
  logic [IW-1:0]      w_winIdx;
  logic               w_accept;
  logic [AW-1:0]      w_winAddr;
  logic [BCW-1:0]     w_bc;
  logic [BCW-1:0]     w_winBeats;
  logic [3:0]         w_nibble;
  logic [15:0]        w_cs16;
  logic               w_mapped;
  logic               w_beatDone;
  logic               w_lastBeat;
  logic               w_moreBeats;

  logic [MASTERS-1:0] r_grant;
  logic [IW-1:0]      r_owner;
  logic [AW-1:0]      r_address;
  logic [DW-1:0]      r_writedata;
  logic [BEW-1:0]     r_be;
  logic [SLAVES-1:0]  r_cs;
  logic [BCW-1:0]     r_beats;
  logic               r_read;
  logic               r_write;
  logic               r_native;
  logic               r_unmapped;

  assign w_req    = bus.m_read | bus.m_write;
  assign w_accept = (r_state == IDLE) && (|w_req);

  bus_rr_arbiter #(
    .MASTERS (MASTERS),
    .RR_MODE (RR_MODE)
  ) u_rr (
    .i_clock     (i_clock),
    .i_reset_n   (i_reset_n),
    .i_req       (w_req),
    .i_accept    (w_accept),
    .o_winner    (w_winner),
    .o_winnerIdx (w_winIdx)
  );

  assign w_winAddr  = bus.m_address[w_winIdx*AW +: AW];
  assign w_bc       = bus.m_burstcount[w_winIdx*BCW +: BCW];
  assign w_winBeats = (w_bc == '0) ? BCW'(1) : w_bc;
  assign w_nibble   = w_winAddr[AW-1 -: 4];
  assign w_cs16     = decode_cs(w_nibble, SLAVES);
  assign w_mapped   = |w_cs16;

  // An unmapped access completes one cycle after ADDR no matter what slave_wait says.
  assign w_beatDone  = (r_state == BEAT) && (r_unmapped || !bus.slave_wait);
  assign w_lastBeat  = w_beatDone && (r_unmapped || (r_beats == BCW'(1)));
  assign w_moreBeats = w_beatDone && !w_lastBeat;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (|w_req) w_nextState = ADDR;
      ADDR:    w_nextState = BEAT;
      BEAT: begin
        if (w_lastBeat)                    w_nextState = IDLE;
        else if (w_moreBeats && !r_native) w_nextState = ADDR;
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_grant     <= '0;
      r_owner     <= '0;
      r_address   <= '0;
      r_writedata <= '0;
      r_be        <= '0;
      r_cs        <= '0;
      r_beats     <= '0;
      r_read      <= 1'b0;
      r_write     <= 1'b0;
      r_native    <= 1'b0;
      r_unmapped  <= 1'b0;
    end else if (w_accept) begin
      r_grant     <= w_winner;
      r_owner     <= w_winIdx;
      r_address   <= w_winAddr;
      r_writedata <= bus.m_writedata[w_winIdx*DW +: DW];
      r_be        <= bus.m_be[w_winIdx*BEW +: BEW];
      r_cs        <= w_cs16[SLAVES-1:0];
      r_beats     <= w_winBeats;
      r_read      <= bus.m_read[w_winIdx];
      r_write     <= !bus.m_read[w_winIdx] && bus.m_write[w_winIdx];
      r_native    <= w_mapped && MASK16[w_nibble] && (w_winBeats > BCW'(1));
      r_unmapped  <= !w_mapped;
    end else if (w_lastBeat) begin
      r_grant    <= '0;
      r_cs       <= '0;
      r_read     <= 1'b0;
      r_write    <= 1'b0;
      r_native   <= 1'b0;
      r_unmapped <= 1'b0;
    end else if (w_moreBeats) begin
      // Chipselect stays put even if the incremented address crosses into another region.
      r_beats     <= r_beats - BCW'(1);
      r_address   <= r_address + STEP;
      r_writedata <= bus.m_writedata[r_owner*DW +: DW];
      r_be        <= bus.m_be[r_owner*BEW +: BEW];
    end
  end

  always_comb begin
    bus.m_wait    = '1;
    if (w_beatDone) bus.m_wait = ~r_grant;
    bus.start     = (r_state == ADDR) && !r_unmapped;
    bus.burst_adv = w_moreBeats && r_native;
    bus.bus_err   = w_beatDone && r_unmapped;
  end

  assign bus.grant      = r_grant;
  assign bus.address    = r_address;
  assign bus.read       = r_read;
  assign bus.write      = r_write;
  assign bus.writedata  = r_writedata;
  assign bus.be         = r_be;
  assign bus.chipselect = r_cs;
  assign bus.burst      = r_native;

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: directed requests push expected beats, a negedge
// monitor pops one entry per completed beat; a fixed-priority twin checks mode 0 grants.
module tb_bus_arbiter;
  import bus_arbiter_pkg::*;

  localparam int MASTERS   = 4;
  localparam int SLAVES    = 10;
  localparam int AW        = 32;
  localparam int DW        = 32;
  localparam int BURST_MAX = 4;
  localparam int BCW       = bcw_of(BURST_MAX);

  typedef struct {
    logic [3:0]  owner;
    logic [31:0] addr;
    logic        rd;
    logic        wr;
    logic [9:0]  cs;
    logic        err;
    logic [31:0] wdata;
  } beat_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bus_arbiter_if #(.MASTERS(MASTERS), .SLAVES(SLAVES), .AW(AW), .DW(DW), .BCW(BCW)) bus ();
  bus_arbiter_if #(.MASTERS(MASTERS), .SLAVES(SLAVES), .AW(AW), .DW(DW), .BCW(BCW)) busF ();

  bus_arbiter #(
    .MASTERS(MASTERS), .SLAVES(SLAVES), .AW(AW), .DW(DW), .BURST_MAX(BURST_MAX),
    .RR_MODE(1'b1), .BURST_MASK(10'h001)
  ) dut (.i_clock(clk), .i_reset_n(rst_n), .bus(bus));

  bus_arbiter #(
    .MASTERS(MASTERS), .SLAVES(SLAVES), .AW(AW), .DW(DW), .BURST_MAX(BURST_MAX),
    .RR_MODE(1'b0), .BURST_MASK(10'h001)
  ) dutFixed (.i_clock(clk), .i_reset_n(rst_n), .bus(busF));

  assign busF.m_read       = bus.m_read;
  assign busF.m_write      = bus.m_write;
  assign busF.m_address    = bus.m_address;
  assign busF.m_writedata  = bus.m_writedata;
  assign busF.m_be         = bus.m_be;
  assign busF.m_burstcount = bus.m_burstcount;
  assign busF.slave_wait   = bus.slave_wait;

  int    checks = 0;
  int    errors = 0;
  int    startCnt, advCnt, burstCyc, errCnt, fixedGrantCyc;
  bit    checkFixed = 1'b0;
  beat_t expQ[$];
  beat_t monExp;
  logic [3:0] monOwner;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input int m, input bit rd, input bit wr, input logic [31:0] addr,
                               input logic [BCW-1:0] bc, input logic [31:0] wd);
    bus.m_read[m]                 = rd;
    bus.m_write[m]                = wr;
    bus.m_address[m*AW +: AW]     = addr;
    bus.m_burstcount[m*BCW +: BCW] = bc;
    bus.m_writedata[m*DW +: DW]   = wd;
    bus.m_be[m*4 +: 4]            = 4'hF;
  endtask

  task automatic pushBeat(input logic [3:0] owner, input logic [31:0] addr, input bit rd, input bit wr,
                          input logic [9:0] cs, input bit err, input logic [31:0] wd);
    beat_t b;
    b.owner = owner; b.addr = addr; b.rd = rd; b.wr = wr; b.cs = cs; b.err = err; b.wdata = wd;
    expQ.push_back(b);
  endtask

  task automatic clearCounters();
    startCnt = 0; advCnt = 0; burstCyc = 0; errCnt = 0; fixedGrantCyc = 0;
  endtask

  // Waits for all expected beats, then drops every request in the following IDLE cycle.
  task automatic waitDrain(input string name, input int budget);
    for (int i = 0; i < budget && expQ.size() != 0; i++) @(posedge clk);
    if (expQ.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_timeout: %0d beats still pending, expected 0", name, expQ.size());
      expQ.delete();
    end
    #1;
    bus.m_read  = '0;
    bus.m_write = '0;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.start)     startCnt++;
      if (bus.burst_adv) advCnt++;
      if (bus.burst)     burstCyc++;
      if (bus.bus_err)   errCnt++;
      if (checkFixed && busF.grant != '0) begin
        fixedGrantCyc++;
        checkOutput("fixed_grant", {60'd0, busF.grant}, 64'h1);
      end
      if (bus.m_wait !== 4'hF) begin
        monOwner = ~bus.m_wait;
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_beat: m_wait=0x%0h, expected no beat", bus.m_wait);
        end else begin
          monExp = expQ.pop_front();
          checkOutput("beat_owner", {60'd0, monOwner}, {60'd0, monExp.owner});
          checkOutput("beat_grant", {60'd0, bus.grant}, {60'd0, monExp.owner});
          checkOutput("beat_addr", {32'd0, bus.address}, {32'd0, monExp.addr});
          checkOutput("beat_cs", {54'd0, bus.chipselect}, {54'd0, monExp.cs});
          checkOutput("beat_err", {63'd0, bus.bus_err}, {63'd0, monExp.err});
          if (!monExp.err) begin
            checkOutput("beat_read", {63'd0, bus.read}, {63'd0, monExp.rd});
            checkOutput("beat_write", {63'd0, bus.write}, {63'd0, monExp.wr});
          end
          if (monExp.wr) checkOutput("beat_wdata", {32'd0, bus.writedata}, {32'd0, monExp.wdata});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.m_read = '0; bus.m_write = '0; bus.m_address = '0; bus.m_writedata = '0;
    bus.m_be = '0; bus.m_burstcount = '0; bus.slave_wait = 1'b0;
    clearCounters();

    #12;
    checkOutput("rst_m_wait", {60'd0, bus.m_wait}, 64'hF);
    checkOutput("rst_grant", {60'd0, bus.grant}, 64'h0);
    checkOutput("rst_address", {32'd0, bus.address}, 64'h0);
    checkOutput("rst_rw", {62'd0, bus.read, bus.write}, 64'h0);
    checkOutput("rst_cs", {54'd0, bus.chipselect}, 64'h0);
    checkOutput("rst_strobes", {60'd0, bus.start, bus.burst, bus.burst_adv, bus.bus_err}, 64'h0);
    #20 rst_n = 1'b1;

    // Round robin: all four masters hold single reads; fixed twin must only serve M0.
    @(posedge clk); #1;
    clearCounters();
    checkFixed = 1'b1;
    for (int i = 0; i < 4; i++) applyStimulus(i, 1'b1, 1'b0, 32'h2000_0000 + 32'(i * 16), 3'd1, 32'h0);
    pushBeat(4'b0001, 32'h2000_0000, 1, 0, 10'h004, 0, 0);
    pushBeat(4'b0010, 32'h2000_0010, 1, 0, 10'h004, 0, 0);
    pushBeat(4'b0100, 32'h2000_0020, 1, 0, 10'h004, 0, 0);
    pushBeat(4'b1000, 32'h2000_0030, 1, 0, 10'h004, 0, 0);
    pushBeat(4'b0001, 32'h2000_0000, 1, 0, 10'h004, 0, 0);
    waitDrain("rr", 100);
    checkFixed = 1'b0;
    checkOutput("fixed_granted_any", {63'd0, fixedGrantCyc > 0}, 64'h1);

    // Single read cycle timing, request held so the second grant lands at cycle 4.
    @(posedge clk); #1;
    clearCounters();
    applyStimulus(0, 1'b1, 1'b0, 32'h6000_0010, 3'd1, 32'h0);
    pushBeat(4'b0001, 32'h6000_0010, 1, 0, 10'h040, 0, 0);
    pushBeat(4'b0001, 32'h6000_0010, 1, 0, 10'h040, 0, 0);
    @(negedge clk);
    checkOutput("m0_c0_start", {63'd0, bus.start}, 64'h0);
    checkOutput("m0_c0_grant", {60'd0, bus.grant}, 64'h0);
    @(negedge clk);
    checkOutput("m0_c1_start", {63'd0, bus.start}, 64'h1);
    checkOutput("m0_c1_cs", {54'd0, bus.chipselect}, 64'h040);
    checkOutput("m0_c1_grant", {60'd0, bus.grant}, 64'h1);
    checkOutput("m0_c1_wait", {60'd0, bus.m_wait}, 64'hF);
    @(negedge clk);
    checkOutput("m0_c2_wait", {60'd0, bus.m_wait}, 64'hE);
    checkOutput("m0_c2_start", {63'd0, bus.start}, 64'h0);
    @(negedge clk);
    checkOutput("m0_c3_grant", {60'd0, bus.grant}, 64'h0);
    checkOutput("m0_c3_wait", {60'd0, bus.m_wait}, 64'hF);
    checkOutput("m0_c3_read", {63'd0, bus.read}, 64'h0);
    @(negedge clk);
    checkOutput("m0_c4_grant", {60'd0, bus.grant}, 64'h1);
    waitDrain("m0", 50);

    // Native 4-beat SSRAM read.
    @(posedge clk); #1;
    clearCounters();
    applyStimulus(1, 1'b1, 1'b0, 32'h0000_0100, 3'd4, 32'h0);
    for (int i = 0; i < 4; i++) pushBeat(4'b0010, 32'h0000_0100 + 32'(i * 4), 1, 0, 10'h001, 0, 0);
    waitDrain("m1_burst", 50);
    checkOutput("m1_starts", 64'(startCnt), 64'd1);
    checkOutput("m1_adv", 64'(advCnt), 64'd3);
    checkOutput("m1_burst_cycles", 64'(burstCyc), 64'd5);

    // Split 2-beat write to a non-burst slave.
    @(posedge clk); #1;
    clearCounters();
    applyStimulus(2, 1'b0, 1'b1, 32'h4000_0020, 3'd2, 32'hDEAD_BEEF);
    pushBeat(4'b0100, 32'h4000_0020, 0, 1, 10'h010, 0, 32'hDEAD_BEEF);
    pushBeat(4'b0100, 32'h4000_0024, 0, 1, 10'h010, 0, 32'hDEAD_BEEF);
    waitDrain("m2_split", 50);
    checkOutput("m2_starts", 64'(startCnt), 64'd2);
    checkOutput("m2_burst_cycles", 64'(burstCyc), 64'd0);
    checkOutput("m2_adv", 64'(advCnt), 64'd0);

    // Native burst crossing into the next region keeps its chipselect.
    @(posedge clk); #1;
    clearCounters();
    applyStimulus(2, 1'b1, 1'b0, 32'h0FFF_FFFC, 3'd2, 32'h0);
    pushBeat(4'b0100, 32'h0FFF_FFFC, 1, 0, 10'h001, 0, 0);
    pushBeat(4'b0100, 32'h1000_0000, 1, 0, 10'h001, 0, 0);
    waitDrain("cross", 50);
    checkOutput("cross_adv", 64'(advCnt), 64'd1);
    checkOutput("cross_burst_cycles", 64'(burstCyc), 64'd3);

    // Slave stretches the beat for five cycles.
    @(posedge clk); #1;
    clearCounters();
    bus.slave_wait = 1'b1;
    applyStimulus(3, 1'b0, 1'b1, 32'h3000_0000, 3'd1, 32'h1234_5678);
    pushBeat(4'b1000, 32'h3000_0000, 0, 1, 10'h008, 0, 32'h1234_5678);
    for (int i = 0; i < 20 && bus.grant[3] !== 1'b1; i++) @(negedge clk);
    checkOutput("sw_grant", {60'd0, bus.grant}, 64'h8);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("sw_hold_wait", {60'd0, bus.m_wait}, 64'hF);
      checkOutput("sw_hold_addr", {32'd0, bus.address}, 64'h3000_0000);
      checkOutput("sw_hold_cs", {54'd0, bus.chipselect}, 64'h008);
    end
    @(posedge clk); #1;
    bus.slave_wait = 1'b0;
    waitDrain("slave_wait", 50);
    checkOutput("sw_starts", 64'(startCnt), 64'd1);

    // Unmapped address: one error beat, remaining beats discarded.
    @(posedge clk); #1;
    clearCounters();
    applyStimulus(0, 1'b1, 1'b0, 32'hF000_0000, 3'd3, 32'h0);
    pushBeat(4'b0001, 32'hF000_0000, 1, 0, 10'h000, 1, 0);
    waitDrain("unmapped", 50);
    repeat (4) @(posedge clk);
    checkOutput("unmapped_starts", 64'(startCnt), 64'd0);
    checkOutput("unmapped_err_pulses", 64'(errCnt), 64'd1);

    // Asynchronous reset in the middle of a native burst.
    @(posedge clk); #1;
    applyStimulus(1, 1'b1, 1'b0, 32'h0000_0200, 3'd4, 32'h0);
    for (int i = 0; i < 4; i++) pushBeat(4'b0010, 32'h0000_0200 + 32'(i * 4), 1, 0, 10'h001, 0, 0);
    for (int i = 0; i < 50 && expQ.size() > 2; i++) @(posedge clk);
    checkOutput("mid_burst_progress", 64'(expQ.size()), 64'd2);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("arst_m_wait", {60'd0, bus.m_wait}, 64'hF);
    checkOutput("arst_grant", {60'd0, bus.grant}, 64'h0);
    checkOutput("arst_address", {32'd0, bus.address}, 64'h0);
    checkOutput("arst_cs", {54'd0, bus.chipselect}, 64'h0);
    checkOutput("arst_rw", {62'd0, bus.read, bus.write}, 64'h0);
    checkOutput("arst_strobes", {60'd0, bus.start, bus.burst, bus.burst_adv, bus.bus_err}, 64'h0);
    expQ.delete();
    bus.m_read  = '0;
    bus.m_write = '0;
    #10 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("post_rst_grant", {60'd0, bus.grant}, 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
